// File: rtl/fb_swap_pkg.sv
// Shared constants for the frame-buffer swap scheduler: CSR map, FSM state codes
// and STATUS/CTRL bit positions.
package fb_swap_pkg;

  localparam logic [2:0] CsrCtrl     = 3'd0;
  localparam logic [2:0] CsrBuf0     = 3'd1;
  localparam logic [2:0] CsrBuf1     = 3'd2;
  localparam logic [2:0] CsrSwap     = 3'd3;
  localparam logic [2:0] CsrStatus   = 3'd4;
  localparam logic [2:0] CsrFrameCnt = 3'd5;
  localparam logic [2:0] CsrIrqClr   = 3'd7;

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t StIdle   = 2'd0;
  localparam fsm_state_t StWrAddr = 2'd1;
  localparam fsm_state_t StWrGo   = 2'd2;

  localparam int unsigned CtrlEnableBit    = 0;
  localparam int unsigned CtrlIrqEnBit     = 1;
  localparam int unsigned StatusPendingBit = 0;
  localparam int unsigned StatusFrontBit   = 1;
  localparam int unsigned StatusBusyBit    = 2;
  localparam int unsigned StatusIrqBit     = 3;

endpackage

// File: rtl/fb_vsync_sync.sv
// Two-flop synchronizer for an ITC sync input followed by a registered
// rising-edge detector producing a single-cycle pulse.
module fb_vsync_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic pulse_o
);

  // [0],[1] are the synchronizer stages, [2] is the edge-detect history
  logic [2:0] sync_q;
  logic       pulse_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], async_i};
      pulse_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/fb_swap_sched.sv
// Double-buffer swap scheduler: defers buffer flips to vsync and reprograms the
// frame reader over Avalon-MM. Optional interrupt enabled by FB_SWAP_IRQ_EN.
module fb_swap_sched
  import fb_swap_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned REG_ADDR_OFS = 4,
  parameter int unsigned REG_GO_OFS   = 0,
  parameter int unsigned GO_VALUE     = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [2:0]        csr_address_i,
  input  logic              csr_write_i,
  input  logic [31:0]       csr_writedata_i,
  input  logic              csr_read_i,
  output logic [31:0]       csr_readdata_o,
  input  logic              vsync_async_i,
  output logic [3:0]        m_address_o,
  output logic              m_write_o,
  output logic [ADDR_W-1:0] m_writedata_o,
  input  logic              m_waitrequest_i,
`ifdef FB_SWAP_IRQ_EN
  output logic              irq_o,
`endif
  output logic              busy_o
);

  logic              vs_pulse;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d, tgt_addr_q, tgt_addr_d;
  logic              pending_q, pending_d, front_q, front_d;
  logic              init_req_q, init_req_d, target_q, target_d, seq_init_q, seq_init_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  fsm_state_t        state_q, state_d;
  logic              enable, go_done, swap_done;

  fb_vsync_sync u_vsync_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (vsync_async_i),
    .pulse_o (vs_pulse)
  );

  assign enable    = ctrl_q[CtrlEnableBit];
  assign go_done   = (state_q == StWrGo) && !m_waitrequest_i;
  assign swap_done = go_done && !seq_init_q;

  always_comb begin
    ctrl_d      = ctrl_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    pending_d   = pending_q;
    front_d     = front_q;
    init_req_d  = init_req_q;
    frame_cnt_d = frame_cnt_q;
    state_d     = state_q;
    tgt_addr_d  = tgt_addr_q;
    target_d    = target_q;
    seq_init_d  = seq_init_q;

    if (vs_pulse && enable) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (init_req_q && enable) begin
          state_d    = StWrAddr;
          target_d   = front_q;
          seq_init_d = 1'b1;
          tgt_addr_d = front_q ? buf1_q : buf0_q;
        end else if (enable && pending_q && vs_pulse) begin
          state_d    = StWrAddr;
          target_d   = ~front_q;
          seq_init_d = 1'b0;
          tgt_addr_d = front_q ? buf0_q : buf1_q;
        end
      end
      StWrAddr: begin
        if (!m_waitrequest_i) state_d = StWrGo;
      end
      StWrGo: begin
        if (!m_waitrequest_i) begin
          state_d = StIdle;
          front_d = target_q;
          if (seq_init_q) init_req_d = 1'b0;
          else            pending_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // A pending init is dropped if enable falls before its sequence starts
    if (state_q == StIdle && !enable) init_req_d = 1'b0;

    if (csr_write_i) begin
      case (csr_address_i)
        CsrCtrl: begin
`ifdef FB_SWAP_IRQ_EN
          ctrl_d = csr_writedata_i[1:0];
`else
          ctrl_d = {1'b0, csr_writedata_i[0]};
`endif
          if (csr_writedata_i[0] && !enable) init_req_d = 1'b1;
        end
        CsrBuf0: buf0_d    = ADDR_W'(csr_writedata_i);
        CsrBuf1: buf1_d    = ADDR_W'(csr_writedata_i);
        CsrSwap: pending_d = 1'b1;  // set wins over a same-cycle completion clear
        default: ;
      endcase
    end
  end

`ifdef FB_SWAP_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (csr_write_i && csr_address_i == CsrIrqClr) irq_d = 1'b0;
    if (swap_done) irq_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) irq_q <= 1'b0;
    else         irq_q <= irq_d;
  end

  assign irq_o = irq_q & ctrl_q[CtrlIrqEnBit];
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (csr_read_i) begin
      rdata_d = '0;
      case (csr_address_i)
        CsrCtrl:     rdata_d[1:0] = ctrl_q;
        CsrBuf0:     rdata_d = 32'(buf0_q);
        CsrBuf1:     rdata_d = 32'(buf1_q);
        CsrSwap:     rdata_d[0] = pending_q;
        CsrStatus: begin
          rdata_d[StatusPendingBit] = pending_q;
          rdata_d[StatusFrontBit]   = front_q;
          rdata_d[StatusBusyBit]    = (state_q != StIdle);
`ifdef FB_SWAP_IRQ_EN
          rdata_d[StatusIrqBit]     = irq_q;
`endif
        end
        CsrFrameCnt: rdata_d = 32'(frame_cnt_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ctrl_q      <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      pending_q   <= 1'b0;
      front_q     <= 1'b0;
      init_req_q  <= 1'b0;
      frame_cnt_q <= '0;
      state_q     <= StIdle;
      tgt_addr_q  <= '0;
      target_q    <= 1'b0;
      seq_init_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      pending_q   <= pending_d;
      front_q     <= front_d;
      init_req_q  <= init_req_d;
      frame_cnt_q <= frame_cnt_d;
      state_q     <= state_d;
      tgt_addr_q  <= tgt_addr_d;
      target_q    <= target_d;
      seq_init_q  <= seq_init_d;
      rdata_q     <= rdata_d;
    end
  end

  // Master outputs decode straight from state so reset drops m_write at once
  always_comb begin
    m_write_o     = 1'b0;
    m_address_o   = '0;
    m_writedata_o = '0;
    unique case (state_q)
      StWrAddr: begin
        m_write_o     = 1'b1;
        m_address_o   = 4'(REG_ADDR_OFS);
        m_writedata_o = tgt_addr_q;
      end
      StWrGo: begin
        m_write_o     = 1'b1;
        m_address_o   = 4'(REG_GO_OFS);
        m_writedata_o = ADDR_W'(GO_VALUE);
      end
      default: ;
    endcase
  end

  assign busy_o         = (state_q != StIdle);
  assign csr_readdata_o = rdata_q;

endmodule

// File: doc/fb_swap_sched.md
Name: fb_swap_sched

Overview:
- Double-buffer swap scheduler for the shared-memory VGA path.
- The host/kernel side renders into one of two DDR frame buffers while the video frame reader scans out the other.
- A swap request is deferred to the next vertical sync. At that point the block reprograms the frame reader base address over an Avalon-MM master. This gives tear-free buffer flips without CPU timing.
- Sits in the acl_iface subsystem between the HPS CSR bridge, the frame reader control slave and the ITC sync output.

Parameters:
- ADDR_W, 32, width of frame buffer base addresses and master writedata.
- REG_ADDR_OFS, 4, word offset of the frame reader base-address register.
- REG_GO_OFS, 0, word offset of the frame reader control/go register.
- GO_VALUE, 1, value written to REG_GO_OFS to commit.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- csr_address  in  3  CSR word address.
- csr_write  in  1  CSR write strobe.
- csr_writedata  in  32  CSR write data.
- csr_read  in  1  CSR read strobe.
- csr_readdata  out  32  CSR read data; fixed read latency 1.
- vsync_async  in  1  vid_v_sync from the ITC; asynchronous to clk.
- m_address  out  4  frame reader register word address.
- m_write  out  1  master write request.
- m_writedata  out  ADDR_W  master write data.
- m_waitrequest  in  1  frame reader stall.
- busy  out  1  programming sequence in progress.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - all outputs to 0;
  - CTRL, BUF0, BUF1, pending, front and FRAME_CNT to 0;
  - FSM to IDLE.
- CSR map (word address):
  - 0 CTRL: bit0 = enable.
  - 1 BUF0 base.
  - 2 BUF1 base.
  - 3 SWAP: a write of any value sets pending; a read returns pending in bit0.
  - 4 STATUS: bit0 pending, bit1 front, bit2 busy.
  - 5 FRAME_CNT.
  - 6–7 read 0; writes to them are ignored.
- csr_readdata is registered, valid the cycle after csr_read, and holds its value otherwise.
- vsync_async passes through a 2-FF synchronizer plus rising-edge detect, giving a 1-cycle vs_pulse 3 clk after the synchronized edge.
- FRAME_CNT increments on each vs_pulse while enable=1 and wraps at 2^CNT_W.
- init_req is set on an enable 0→1 edge. It is cleared when its sequence completes, and also cleared if enable returns to 0 before the sequence starts.
- FSM transitions:
  - IDLE → WR_ADDR when init_req: target=front, latch tgt_addr=BUF[front] (no vsync wait).
  - Otherwise IDLE → WR_ADDR when enable and pending and vs_pulse: target=~front, latch tgt_addr=BUF[~front].
  - WR_ADDR: m_write=1, m_address=REG_ADDR_OFS, m_writedata=tgt_addr. All held stable while m_waitrequest=1. Accept (m_write and !m_waitrequest) → WR_GO.
  - WR_GO: m_write=1, m_address=REG_GO_OFS, m_writedata=GO_VALUE. Accept → IDLE. On that edge: front<=target; pending cleared if the sequence was a swap; init_req cleared if it was init.
- busy=1 in WR_ADDR and WR_GO.
- Minimum swap sequence is 2 clk with no waitrequest.
- Boundary rules:
  - A SWAP write on the same cycle that pending clears: the set wins, so pending stays 1.
  - A vs_pulse during busy is ignored for swapping but still counted in FRAME_CNT.
  - Multiple SWAP writes before a vsync collapse into one swap.
  - BUFn writes during busy do not affect the in-flight sequence because tgt_addr is latched.
  - Enable cleared mid-sequence: the current sequence completes, since an Avalon write cannot be withdrawn; no new sequences start; pending is retained.
  - Reset mid-sequence aborts immediately, and m_write drops asynchronously.

Optional Feature:
- Macro: FB_SWAP_IRQ_EN.
- With it defined:
  - adds output irq (1 bit), set on completion of a swap sequence (not init);
  - CTRL bit1 = irq enable, gating the irq output;
  - a write to CSR 7 clears the irq;
  - set wins over a same-cycle clear;
  - STATUS bit3 = raw irq.
- Without it: no irq port, CTRL bit1 reads 0, CSR 7 is inert.

Decomposition:
- Package fb_swap_pkg holds:
  - the CSR word-address localparams (CTRL..IRQ_CLR);
  - the FSM state enum typedef (IDLE, WR_ADDR, WR_GO);
  - STATUS bit-index constants.
- One natural sub-module: fb_vsync_sync (2-FF synchronizer plus rising-edge pulse), reusable for the other ITC sync inputs.

Test Plan:
- Set BUF0=0x3000_0000, BUF1=0x3100_0000, write CTRL=1 → without a vsync, master writes 0x3000_0000 @4 then 1 @0; front=0; busy for 2 clk.
- Write SWAP, then toggle vsync_async high → 3 clk after sync edge master writes 0x3100_0000 @4, 1 @0; STATUS reads front=1, pending=0.
- Hold m_waitrequest=1 for 5 clk during WR_ADDR → address and data stay stable; accepted on cycle 6; WR_GO follows.
- SWAP written on the cycle WR_GO is accepted → pending remains 1; next vsync swaps back to front=0.
- Clear enable during WR_ADDR → sequence completes; later vsync with pending=1 produces no master writes; FRAME_CNT frozen.
- FB_SWAP_IRQ_EN build with CTRL=3: after a swap irq=1; write CSR 7 → irq=0 next clk; init sequence leaves irq=0.
